// File: rtl/grf_pkg.sv
// Shared definitions for the general-purpose register file and its neighbours
// (write-address selector, result checker). Register numbering constants and
// the commit log format live here so every stage prints and decodes the same way.
package grf_pkg;

  localparam int         REG_NUM  = 32;
  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_RA   = 5'd31;

`ifndef SYNTHESIS
  // Commit log line: "@<pc hex>: $<reg dec> <= <data hex>"
  function automatic string grf_log_line(input logic [31:0] pc,
                                         input logic [4:0]  a3,
                                         input logic [31:0] wd);
    return $sformatf("@%h: $%d <= %h", pc, a3, wd);
  endfunction
`endif

endpackage

// File: rtl/grf.sv
// grf: 32 x 32-bit MIPS general-purpose register file.
// Two combinational read ports, one synchronous write port, $0 hardwired to 0.
// Synchronous active-low reset clears every register and takes priority over
// a write on the same edge. Each committed write (reset high, WE high) prints
// a log line for the result checker, including writes aimed at $0.
// Optional feature: define GRF_BYPASS_EN to forward WD to a read port in the
// same cycle when that port reads the register being written (pipelined core).
module grf
  import grf_pkg::*;
#(
  parameter int REG_W  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              WE,
  input  logic [ADDR_W-1:0] A1,
  input  logic [ADDR_W-1:0] A2,
  input  logic [ADDR_W-1:0] A3,
  input  logic [REG_W-1:0]  WD,
  input  logic [31:0]       PC,
  output logic [REG_W-1:0]  RD1,
  output logic [REG_W-1:0]  RD2
);

  logic [REG_W-1:0] r_regs [REG_NUM];
  logic             w_wr_commit;
  logic [REG_W-1:0] w_rd1;
  logic [REG_W-1:0] w_rd2;

  // A write only lands when out of reset and not targeting $0.
  assign w_wr_commit = reset && WE && (A3 != REG_ZERO);

  // Register array update: reset clears everything, otherwise commit the write.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < REG_NUM; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_commit) begin
      r_regs[A3] <= WD;
    end
  end

`ifndef SYNTHESIS
  // Commit log for the result checker; $0 writes are logged even though dropped.
  always_ff @(posedge clk) begin
    if (reset && WE) begin
      $display("%s", grf_log_line(PC, A3, WD));
    end
  end
`endif

  // Read muxing: $0 reads zero; optional same-cycle forwarding of WD.
  always_comb begin
    w_rd1 = (A1 == REG_ZERO) ? '0 : r_regs[A1];
    w_rd2 = (A2 == REG_ZERO) ? '0 : r_regs[A2];
`ifdef GRF_BYPASS_EN
    if (w_wr_commit && (A3 == A1)) w_rd1 = WD;
    if (w_wr_commit && (A3 == A2)) w_rd2 = WD;
`endif
  end

  assign RD1 = w_rd1;
  assign RD2 = w_rd2;

endmodule

// File: tb/tb_grf.sv
// Directed bench for grf: reset clearing, basic writes, $0 immunity,
// same-cycle read/write behaviour (both build variants), reset priority over
// a write, and back-to-back writes to one register.
module tb_grf;

  logic        clk;
  logic        reset;
  logic        WE;
  logic [4:0]  A1, A2, A3;
  logic [31:0] WD, PC;
  logic [31:0] RD1, RD2;

  int n_vec;
  int n_miss;

  grf dut (
    .clk   (clk),
    .reset (reset),
    .WE    (WE),
    .A1    (A1),
    .A2    (A2),
    .A3    (A3),
    .WD    (WD),
    .PC    (PC),
    .RD1   (RD1),
    .RD2   (RD2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge; return shortly after it so outputs have settled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Combinational settle after changing inputs, well away from any edge.
  task automatic settle();
    #1;
  endtask

  logic        bypass;
  logic [31:0] exp_v;

  initial begin
    n_vec  = 0;
    n_miss = 0;
`ifdef GRF_BYPASS_EN
    bypass = 1'b1;
`else
    bypass = 1'b0;
`endif
    reset = 1'b0;
    WE    = 1'b0;
    A1    = '0;
    A2    = '0;
    A3    = '0;
    WD    = '0;
    PC    = '0;

    // Reset for one edge, then every address on both ports must read 0.
    tick();
    reset = 1'b1;
    for (int i = 0; i < 32; i++) begin
      A1 = 5'(i);
      A2 = 5'(31 - i);
      settle();
      check_val($sformatf("rst_rd1_%0d", i), RD1, 32'h0);
      check_val($sformatf("rst_rd2_%0d", 31 - i), RD2, 32'h0);
    end

    // Plain write to $5, read back on port 1; pre-edge read depends on bypass.
    WE = 1'b1; A3 = 5'd5; WD = 32'h1234_5678; PC = 32'h0000_3000; A1 = 5'd5; A2 = 5'd6;
    settle();
    exp_v = bypass ? 32'h1234_5678 : 32'h0;
    check_val("w5_pre_rd1", RD1, exp_v);
    check_val("w5_pre_rd2_other", RD2, 32'h0);
    tick();
    WE = 1'b0;
    settle();
    check_val("w5_post_rd1", RD1, 32'h1234_5678);
    A2 = 5'd5;
    settle();
    check_val("w5_post_rd2_same", RD2, 32'h1234_5678);

    // Write to $0 must never be visible, not even via bypass.
    WE = 1'b1; A3 = 5'd0; WD = 32'hFFFF_FFFF; PC = 32'h0000_3004; A1 = 5'd0; A2 = 5'd0;
    settle();
    check_val("w0_pre_rd1", RD1, 32'h0);
    check_val("w0_pre_rd2", RD2, 32'h0);
    tick();
    WE = 1'b0;
    settle();
    check_val("w0_post_rd1", RD1, 32'h0);
    check_val("w0_post_rd2", RD2, 32'h0);

    // Same-cycle read of the register being written ($31).
    WE = 1'b1; A3 = 5'd31; WD = 32'h0000_300C; PC = 32'h0000_3008; A1 = 5'd31; A2 = 5'd31;
    settle();
    exp_v = bypass ? 32'h0000_300C : 32'h0;
    check_val("w31_pre_rd1", RD1, exp_v);
    check_val("w31_pre_rd2", RD2, exp_v);
    tick();
    WE = 1'b0;
    settle();
    check_val("w31_post_rd1", RD1, 32'h0000_300C);
    check_val("w31_post_rd2", RD2, 32'h0000_300C);

    // Write $8, then reset together with a write to $8: reset wins.
    WE = 1'b1; A3 = 5'd8; WD = 32'hA5A5_A5A5; PC = 32'h0000_3010; A1 = 5'd8; A2 = 5'd5;
    tick();
    settle();
    check_val("w8_post", RD1, 32'hA5A5_A5A5);
    reset = 1'b0; WE = 1'b1; A3 = 5'd8; WD = 32'h0000_0001; PC = 32'h0000_3014;
    settle();
    check_val("rst_w8_pre_nobypass", RD1, 32'hA5A5_A5A5);
    tick();
    reset = 1'b1; WE = 1'b0;
    settle();
    check_val("rst_w8_post_rd1", RD1, 32'h0);
    check_val("rst_w5_post_rd2", RD2, 32'h0);
    A1 = 5'd31;
    settle();
    check_val("rst_w31_post_rd1", RD1, 32'h0);

    // Back-to-back writes 1, 2, 3 to $1 observed on port 2.
    A2 = 5'd1; A1 = 5'd2; A3 = 5'd1; WE = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      WD = 32'(k);
      PC = 32'h0000_3020 + 32'(4 * k);
      tick();
      check_val($sformatf("b2b_rd2_%0d", k), RD2, 32'(k));
      check_val($sformatf("b2b_rd1_untouched_%0d", k), RD1, 32'h0);
    end
    WE = 1'b0;
    settle();
    check_val("b2b_final_rd2", RD2, 32'h3);

    // Holding WE with identical inputs keeps the stored value unchanged.
    WE = 1'b1; A3 = 5'd7; WD = 32'hDEAD_BEEF; A1 = 5'd7;
    tick();
    tick();
    WE = 1'b0;
    settle();
    check_val("hold_w7", RD1, 32'hDEAD_BEEF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
